// File: rtl/mux21_rr_arbiter.sv
// Round-robin arbiter for a shared 2:1 mux: grants A or B, drives select s,
// and forwards the owner's data on y with a hold limit against starvation.
module mux21_rr_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             s,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  localparam int            CW      = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);
  localparam logic          LAST_A  = 1'b0;
  localparam logic          LAST_B  = 1'b1;

  typedef enum logic [1:0] {IDLE = 2'd0, GA = 2'd1, GB = 2'd2} state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          last_r, last_s;
  logic          gnt_a_r, gnt_b_r, s_r;
  logic          hold_done_s;

  // next-state selection
  always_comb begin
    state_s     = state_r;
    hold_done_s = (cnt_r == CNT_MAX);
    case (state_r)
      IDLE: begin
        if (req_a && req_b) begin
          state_s = (last_r == LAST_B) ? GA : GB;
        end else if (req_a) begin
          state_s = GA;
        end else if (req_b) begin
          state_s = GB;
        end else begin
          state_s = IDLE;
        end
      end
      GA: begin
        if (!req_a && req_b) begin
          state_s = GB;
        end else if (!req_a && !req_b) begin
          state_s = IDLE;
        end else if (req_b && hold_done_s) begin
          state_s = GB;
        end else begin
          state_s = GA;
        end
      end
      GB: begin
        if (!req_b && req_a) begin
          state_s = GA;
        end else if (!req_b && !req_a) begin
          state_s = IDLE;
        end else if (req_a && hold_done_s) begin
          state_s = GA;
        end else begin
          state_s = GB;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // hold counter restarts on every entry and saturates while the owner keeps the grant
  always_comb begin
    cnt_s  = {CW{1'b0}};
    last_s = last_r;
    if (state_s != state_r) begin
      cnt_s = {CW{1'b0}};
      if (state_s == GA) begin
        last_s = LAST_A;
      end else if (state_s == GB) begin
        last_s = LAST_B;
      end else begin
        last_s = last_r;
      end
    end else if (state_s == IDLE) begin
      cnt_s = {CW{1'b0}};
    end else begin
      cnt_s = hold_done_s ? cnt_r : cnt_r + CW'(1);
    end
  end

  // state, pointer, counter and registered grant outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      last_r  <= LAST_B;
      gnt_a_r <= 1'b0;
      gnt_b_r <= 1'b0;
      s_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      last_r  <= last_s;
      gnt_a_r <= (state_s == GA);
      gnt_b_r <= (state_s == GB);
      s_r     <= (state_s == GB);
    end
  end

  // data path: combinational from the grant registers
  always_comb begin
    y = {WIDTH{1'b0}};
    if (gnt_b_r) begin
      y = b;
    end else if (gnt_a_r) begin
      y = a;
    end else begin
      y = {WIDTH{1'b0}};
    end
  end

  assign gnt_a   = gnt_a_r;
  assign gnt_b   = gnt_b_r;
  assign s       = s_r;
  assign y_valid = gnt_a_r | gnt_b_r;

  mux21_rr_arbiter_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .gnt_a (gnt_a_r),
    .gnt_b (gnt_b_r),
    .s     (s_r)
  );

endmodule

// Invariants of the arbiter outputs: exclusive grants and select tracking B's grant.
module mux21_rr_arbiter_chk (
  input logic clk,
  input logic rst,
  input logic gnt_a,
  input logic gnt_b,
  input logic s
);

  grant_exclusive: assert property (@(posedge clk) disable iff (rst) !(gnt_a && gnt_b));
  select_tracks_b: assert property (@(posedge clk) disable iff (rst) (s == gnt_b));

endmodule

// File: tb/tb_mux21_rr_arbiter.sv
// Directed self-checking bench for mux21_rr_arbiter (MAX_HOLD=4 plus a MAX_HOLD=1 instance).
module tb_mux21_rr_arbiter;

  logic clk = 1'b0;
  logic rst, req_a, req_b;
  logic [0:0] a, b;
  logic gnt_a, gnt_b, s, y_valid;
  logic [0:0] y;
  logic gnt_a1, gnt_b1, s1, y_valid1;
  logic [0:0] y1;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux21_rr_arbiter #(.WIDTH(1), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .s(s), .y(y), .y_valid(y_valid)
  );

  mux21_rr_arbiter #(.WIDTH(1), .MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
    .gnt_a(gnt_a1), .gnt_b(gnt_b1), .s(s1), .y(y1), .y_valid(y_valid1)
  );

  // packed view {gnt_a, gnt_b, s, y_valid, y}
  function automatic logic [4:0] obs();
    return {gnt_a, gnt_b, s, y_valid, y[0]};
  endfunction

  function automatic logic [4:0] obs1();
    return {gnt_a1, gnt_b1, s1, y_valid1, y1[0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1; a = 1'b1; b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (obs() !== 5'b00000) begin
        bad++;
        $display("FAIL reset cyc%0d: got %b want %b", i, obs(), 5'b00000);
      end
    end
  endtask

  task automatic test_first_grant();
    rst = 1'b0; req_a = 1'b1; req_b = 1'b0; a = 1'b1; b = 1'b0;
    step();
    total++;
    if (obs() !== 5'b10011) begin
      bad++;
      $display("FAIL first_grant: got %b want %b", obs(), 5'b10011);
    end
  endtask

  task automatic test_rotation();
    logic [4:0] exp;
    rst = 1'b1; step();
    rst = 1'b0; req_a = 1'b1; req_b = 1'b1; a = 1'b0; b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      exp = ((i < 4) || (i >= 8)) ? 5'b10010 : 5'b01111;
      total++;
      if (obs() !== exp) begin
        bad++;
        $display("FAIL rotation cyc%0d: got %b want %b", i, obs(), exp);
      end
    end
  endtask

  task automatic test_handover();
    req_a = 1'b0; req_b = 1'b0; step();
    total++;
    if (obs() !== 5'b00000) begin
      bad++;
      $display("FAIL handover idle: got %b want %b", obs(), 5'b00000);
    end
    req_a = 1'b1; step();
    req_b = 1'b1; step();
    total++;
    if (obs() !== 5'b10010) begin
      bad++;
      $display("FAIL handover hold_a: got %b want %b", obs(), 5'b10010);
    end
    req_a = 1'b0; step();
    total++;
    if (obs() !== 5'b01111) begin
      bad++;
      $display("FAIL handover to_b: got %b want %b", obs(), 5'b01111);
    end
  endtask

  task automatic test_pointer();
    req_a = 1'b1; req_b = 1'b0; step();
    total++;
    if (obs() !== 5'b10010) begin
      bad++;
      $display("FAIL pointer to_a: got %b want %b", obs(), 5'b10010);
    end
    req_a = 1'b0; step();
    req_a = 1'b1; req_b = 1'b1; step();
    total++;
    if (obs() !== 5'b01111) begin
      bad++;
      $display("FAIL pointer tie_b: got %b want %b", obs(), 5'b01111);
    end
  endtask

  task automatic test_reset_mid_grant();
    rst = 1'b1; step();
    total++;
    if (obs() !== 5'b00000) begin
      bad++;
      $display("FAIL midrst drop: got %b want %b", obs(), 5'b00000);
    end
    rst = 1'b0; step();
    total++;
    if (obs() !== 5'b10010) begin
      bad++;
      $display("FAIL midrst regrant_a: got %b want %b", obs(), 5'b10010);
    end
  endtask

  task automatic test_preempt_solo();
    req_a = 1'b0; req_b = 1'b1; a = 1'b1; b = 1'b0;
    for (int i = 0; i < 6; i++) step();
    total++;
    if (obs() !== 5'b01110) begin
      bad++;
      $display("FAIL preempt solo_b: got %b want %b", obs(), 5'b01110);
    end
    req_a = 1'b1; step();
    total++;
    if (obs() !== 5'b10011) begin
      bad++;
      $display("FAIL preempt to_a: got %b want %b", obs(), 5'b10011);
    end
  endtask

  task automatic test_hold1();
    logic [4:0] exp;
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1; a = 1'b1; b = 1'b0; step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      exp = (i % 2 == 0) ? 5'b10011 : 5'b01110;
      total++;
      if (obs1() !== exp) begin
        bad++;
        $display("FAIL hold1 cyc%0d: got %b want %b", i, obs1(), exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; a = 1'b0; b = 1'b0;
    #1;
    test_reset();
    test_first_grant();
    test_rotation();
    test_handover();
    test_pointer();
    test_reset_mid_grant();
    test_preempt_solo();
    test_hold1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
